// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: encodes a one-hot ring to a phase index, checks ring legality and counts revolutions
//   clk, reset (async, active-high)
//   ring_in[WIDTH], ring_valid, err_clear                -> inputs
//   phase, phase_valid, rev_tick, rev_count              -> registered phase tracking
//   err_onehot, err_seq (sticky), err_count              -> error reporting
//   RING_MON_ERR_CNT_EN enables the saturating err_count; otherwise err_count is 0
module ring_phase_monitor #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     ring_valid,
  input  logic                     err_clear,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_valid,
  output logic                     rev_tick,
  output logic [CNT_W-1:0]         rev_count,
  output logic                     err_onehot,
  output logic                     err_seq,
  output logic [ERR_CNT_W-1:0]     err_count
);
  localparam int PW = $clog2(WIDTH);
  typedef enum logic {IDLE, TRACK} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [PW-1:0] idx, phase_n;
  logic [CNT_W-1:0] cnt_n;
  logic is_oh, legal, take, pv_n, tick_n, set_oh, set_seq, eoh_n, eseq_n;
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) if (ring_in[i]) idx = PW'(i);
  end
  assign is_oh = ring_in != '0 && (ring_in & (ring_in - WIDTH'(1))) == '0;
  // in IDLE any one-hot word is an acquire; in TRACK it must be the rotate of prev
  assign legal = is_oh && (state == IDLE || ring_in == {prev[WIDTH-2:0], prev[WIDTH-1]});
  assign take  = ring_valid && legal;
  always_comb begin
    state_n = take ? TRACK : IDLE;
    prev_n  = take ? ring_in : prev;
    phase_n = take ? idx : phase;
    pv_n    = take;
    tick_n  = take && state == TRACK && prev[WIDTH-1];
    cnt_n   = rev_count + CNT_W'(tick_n);
    set_oh  = ring_valid && !is_oh;
    set_seq = ring_valid && is_oh && !legal;
    eoh_n   = set_oh || (err_onehot && !err_clear);
    eseq_n  = set_seq || (err_seq && !err_clear);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prev        <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= '0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      phase       <= phase_n;
      phase_valid <= pv_n;
      rev_tick    <= tick_n;
      rev_count   <= cnt_n;
      err_onehot  <= eoh_n;
      err_seq     <= eseq_n;
    end
  end
`ifdef RING_MON_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] ecnt_n;
  assign ecnt_n = (set_oh || set_seq)
                ? (err_clear ? ERR_CNT_W'(1) : err_count + ERR_CNT_W'(err_count != '1))
                : (err_clear ? '0 : err_count);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_count <= '0;
    else err_count <= ecnt_n;
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed bench with a behavioural phase/revolution model for ring_phase_monitor
module tb_ring_phase_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ring_in = 4'b0100;
  logic       ring_valid = 1'b1;
  logic       err_clear = 1'b0;
  logic [1:0] phase;
  logic       phase_valid, rev_tick, err_onehot, err_seq;
  logic [7:0] rev_count, err_count;
  int checks = 0;
  int failures = 0;

  ring_phase_monitor #(.WIDTH(4), .CNT_W(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ring_in(ring_in), .ring_valid(ring_valid),
    .err_clear(err_clear), .phase(phase), .phase_valid(phase_valid),
    .rev_tick(rev_tick), .rev_count(rev_count), .err_onehot(err_onehot),
    .err_seq(err_seq), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // model: phase as an integer position on a 4-step circle, revolutions as a plain count
  bit m_track = 0;
  int m_pidx = 0, m_phase = 0, m_rev = 0, m_ecnt = 0;
  bit m_pv = 0, m_tick = 0, m_eoh = 0, m_eseq = 0;

  always @(posedge clk or posedge reset) begin
    int ones, ix;
    bit so, ss;
    if (reset) begin
      m_track = 0; m_pidx = 0; m_phase = 0; m_rev = 0; m_ecnt = 0;
      m_pv = 0; m_tick = 0; m_eoh = 0; m_eseq = 0;
    end else begin
      ones = $countones(ring_in);
      ix = 0;
      for (int i = 0; i < 4; i++) if (ring_in[i]) ix = i;
      so = 0; ss = 0; m_tick = 0; m_pv = 0;
      if (!ring_valid) m_track = 0;
      else if (ones != 1) begin so = 1; m_track = 0; end
      else if (!m_track || ix == (m_pidx + 1) % 4) begin
        if (m_track && ix == 0) begin m_tick = 1; m_rev = (m_rev + 1) % 256; end
        m_track = 1; m_pidx = ix; m_phase = ix; m_pv = 1;
      end else begin ss = 1; m_track = 0; end
      m_eoh  = so || (m_eoh && !err_clear);
      m_eseq = ss || (m_eseq && !err_clear);
`ifdef RING_MON_ERR_CNT_EN
      if (so || ss) m_ecnt = err_clear ? 1 : (m_ecnt < 255 ? m_ecnt + 1 : 255);
      else if (err_clear) m_ecnt = 0;
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("phase", 32'(phase), m_phase);
    chk("phase_valid", 32'(phase_valid), 32'(m_pv));
    chk("rev_tick", 32'(rev_tick), 32'(m_tick));
    chk("rev_count", 32'(rev_count), m_rev);
    chk("err_onehot", 32'(err_onehot), 32'(m_eoh));
    chk("err_seq", 32'(err_seq), 32'(m_eseq));
    chk("err_count", 32'(err_count), m_ecnt);
  end

  // drive one sample just after a falling edge; returns once its response is visible
  task automatic cyc(input logic [3:0] r, input logic v, input logic c);
    ring_in = r; ring_valid = v; err_clear = c;
    @(negedge clk);
  endtask

  task automatic rev();
    cyc(4'b0010, 1, 0); cyc(4'b0100, 1, 0); cyc(4'b1000, 1, 0); cyc(4'b0001, 1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("t1_reset_pv", 32'(phase_valid), 0);
    chk("t1_reset_phase", 32'(phase), 0);
    chk("t1_reset_errs", {30'd0, err_onehot, err_seq}, 0);
    reset = 1'b0;
    cyc(4'b0001, 1, 0); cyc(4'b0010, 1, 0); cyc(4'b0100, 1, 0); cyc(4'b1000, 1, 0);
    chk("t2_phase3", 32'(phase), 3);
    chk("t2_no_tick", 32'(rev_tick), 0);
    cyc(4'b0001, 1, 0);
    chk("t2_tick", 32'(rev_tick), 1);
    chk("t2_rev1", 32'(rev_count), 1);
    chk("t2_phase0", 32'(phase), 0);
    cyc(4'b0010, 1, 0);
    cyc(4'b0110, 1, 0);
    chk("t3_err_onehot", 32'(err_onehot), 1);
    chk("t3_pv0", 32'(phase_valid), 0);
`ifdef RING_MON_ERR_CNT_EN
    chk("t3_err_count", 32'(err_count), 1);
`endif
    cyc(4'b0001, 1, 0);
    chk("t3_reacq_pv", 32'(phase_valid), 1);
    chk("t3_reacq_notick", 32'(rev_tick), 0);
    cyc(4'b0010, 1, 0);
    cyc(4'b0010, 1, 0);
    chk("t4_err_seq", 32'(err_seq), 1);
    cyc(4'b1000, 1, 0);
    chk("t4_acq_phase", 32'(phase), 3);
    cyc(4'b0001, 1, 0);
    chk("t4_tick", 32'(rev_tick), 1);
    chk("t4_rev2", 32'(rev_count), 2);
    cyc(4'b0000, 1, 1);
    chk("t5_set_wins", 32'(err_onehot), 1);
    chk("t5_seq_cleared", 32'(err_seq), 0);
    cyc(4'b0000, 0, 1);
    chk("t5_cleared", 32'(err_onehot), 0);
`ifdef RING_MON_ERR_CNT_EN
    chk("t5_err_count", 32'(err_count), 0);
`endif
    cyc(4'b0001, 1, 0);
    for (int i = 0; i < 100; i++) rev();
    chk("t6_rev102", 32'(rev_count), 102);
    cyc(4'b0010, 1, 0); cyc(4'b0100, 1, 0);
    repeat (3) cyc(4'b1000, 0, 0);
    chk("t6_gap_pv", 32'(phase_valid), 0);
    chk("t6_gap_phase_hold", 32'(phase), 2);
    chk("t6_gap_no_err", {30'd0, err_onehot, err_seq}, 0);
    cyc(4'b1000, 1, 0);
    chk("t6_resume_notick", 32'(rev_tick), 0);
    cyc(4'b0001, 1, 0);
    chk("t6_rev103", 32'(rev_count), 103);
    for (int i = 0; i < 152; i++) rev();
    chk("t6_rev255", 32'(rev_count), 255);
    rev();
    chk("t6_wrap_tick", 32'(rev_tick), 1);
    chk("t6_wrap0", 32'(rev_count), 0);
    rev();
    cyc(4'b0010, 1, 0);
    chk("t1_pre_reset_phase", 32'(phase), 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_pv", 32'(phase_valid), 0);
    chk("t1_async_phase", 32'(phase), 0);
    chk("t1_async_rev", 32'(rev_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc(4'b0100, 1, 0);
    chk("t1_post_reset_phase", 32'(phase), 2);
    cyc(4'b1000, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
